eth_rx_hdr_parser: RTL and testbench
====================================

Name: eth_rx_hdr_parser

Overview:
Consumes the byte-wide AXI-stream leaving the MAC RX FIFO. Strips the 14-byte Ethernet II header (destination MAC, source MAC, EtherType) and presents it on a valid/ready header channel. Forwards the remaining payload on a registered AXI-stream for the IP/UDP layer. Flags frames that are too short to carry a header.

Parameters:
AXI_DATA_WIDTH, 8, stream byte width; only 8 is supported.
LOCAL_MAC, 48'h000A35000102, station address used by the optional filter.
CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
clk_100  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_rx_axis_tdata  in  8  byte from RX FIFO
s_rx_axis_tvalid  in  1  byte valid
s_rx_axis_tlast  in  1  last byte of frame
s_rx_axis_trdy  out  1  parser ready for a byte
m_hdr_valid  out  1  header fields valid
m_hdr_rdy  in  1  downstream accepts header
m_hdr_dest_mac  out  48  destination MAC, first byte received is [47:40]
m_hdr_src_mac  out  48  source MAC, first byte received is [47:40]
m_hdr_ethertype  out  16  EtherType, first byte received is [15:8]
m_pld_axis_tdata  out  8  payload byte
m_pld_axis_tvalid  out  1  payload valid
m_pld_axis_tlast  out  1  last payload byte
m_pld_axis_trdy  in  1  payload consumer ready
o_short_err  out  1  one-cycle pulse when a short frame is detected
o_frame_cnt  out  CNT_WIDTH  count of frames whose header was accepted (saturating)
o_err_cnt  out  CNT_WIDTH  count of short frames (saturating)

Behaviour:
- Clock and reset: one clock, clk_100. Reset is reset_n, asynchronous and active-low.
- Reset values: every output is 0, except s_rx_axis_trdy = 1. The FSM enters HDR with byte counter 0.
- A transfer occurs when valid & ready are both high at the rising edge of clk_100.
- FSM HDR: s_rx_axis_trdy = 1.
  - Each transfer shifts the byte into a 112-bit header register and increments the 4-bit counter.
  - tlast on byte index 0..13 (frame of 14 bytes or fewer): pulse o_short_err, increment o_err_cnt, clear the counter, stay in HDR. No header is emitted.
  - 14th byte without tlast: go to HDR_OUT.
- FSM HDR_OUT: m_hdr_valid = 1 and the fields are stable; s_rx_axis_trdy = 0.
  - On m_hdr_rdy: increment o_frame_cnt and go to PLD. m_hdr_valid drops the next cycle.
- FSM PLD: bytes pass through a one-entry register slice. Latency is 1 cycle from input transfer to m_pld_axis_tvalid.
  - s_rx_axis_trdy = m_pld_axis_trdy | ~m_pld_axis_tvalid, so full throughput is sustained with no bubble.
  - Output data and tlast are held stable while tvalid is high and trdy is low.
  - An input transfer with tlast moves the FSM to HDR and clears the counter.
  - The next frame's header bytes may be accepted while the last payload byte still waits in the slice.
- Simultaneous events: a byte transfer into the slice and a drain from it in the same cycle replace the contents without loss.
- Counters saturate at all-ones and never wrap.
- Reset mid-frame: all state clears at once. The remainder of the interrupted frame is parsed as a new header; upstream is responsible for flushing it.

Optional Feature:
ETH_RX_MAC_FILTER_EN
- Defined: at the 14th header byte, the destination MAC is compared with LOCAL_MAC and with FF:FF:FF:FF:FF:FF.
  - On a mismatch, the FSM enters DROP instead of HDR_OUT, and o_filt_cnt (extra output, CNT_WIDTH bits) increments.
  - DROP holds s_rx_axis_trdy = 1, discards bytes until tlast, then returns to HDR. No header and no payload are emitted.
- Undefined: no compare is made, DROP and o_filt_cnt do not exist, and all frames pass.

Decomposition:
- Package eth_rx_pkg:
  - constants ETH_HDR_BYTES = 14, ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF, ETHERTYPE_IPV4 = 16'h0800;
  - typedefs mac_addr_t (48 bits), ethertype_t (16 bits);
  - enum parser_state_t {HDR, HDR_OUT, PLD, DROP}.
- Sub-module axis_reg_slice: single-entry payload register carrying tdata/tvalid/tlast with the ready rule above. It is reusable by the later IP/UDP stages.

Test Plan:
1. Frame with dest 00:0A:35:00:01:02, src DE:AD:BE:EF:00:01, type 0x0800, payload 0x00..0x2D (46 bytes), m_hdr_rdy and trdy held at 1 -> header fields match exactly; 46 payload bytes in order with tlast only on 0x2D; o_frame_cnt = 1.
2. Same frame with m_hdr_rdy held low for 10 cycles and random 50% m_pld_axis_trdy -> s_rx_axis_trdy = 0 throughout HDR_OUT; header held stable; payload is lossless and bit-exact.
3. 10-byte frame with tlast, then a valid 60-byte frame -> o_short_err high for exactly 1 cycle; o_err_cnt = 1; no m_hdr_valid for the first frame; second frame parsed correctly.
4. 14-byte frame ending in tlast -> treated as short: o_err_cnt increments and no header is emitted.
5. With ETH_RX_MAC_FILTER_EN: frames to 11:22:33:44:55:66, FF:FF:FF:FF:FF:FF and LOCAL_MAC -> first dropped (o_filt_cnt = 1, no output); the other two emitted. Without the macro, all three are emitted.
6. reset_n pulsed low mid-payload -> all outputs 0 asynchronously and s_rx_axis_trdy = 1; a subsequent clean frame parses correctly.

Source files
------------

// File: rtl/eth_rx_hdr_parser_pkg.sv
// Shared types and constants for the Ethernet II receive header parser.
package eth_rx_pkg;

  localparam int ETH_HDR_BYTES = 14;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  localparam mac_addr_t  ETH_BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam ethertype_t ETHERTYPE_IPV4 = 16'h0800;

  typedef enum logic [1:0] {HDR, HDR_OUT, PLD, DROP} parser_state_t;

  // A frame is ours if addressed to the station or to broadcast.
  function automatic logic mac_accepted(input mac_addr_t dest, input mac_addr_t local_mac);
    return (dest == local_mac) || (dest == ETH_BCAST_MAC);
  endfunction

endpackage

// File: rtl/eth_rx_hdr_parser_if.sv
// Bus bundle of the header parser: RX stream in, header channel and payload stream out.
// master = parser side, slave = surrounding logic.
interface eth_rx_hdr_parser_if #(parameter int AXI_DATA_WIDTH = 8);
  import eth_rx_pkg::*;

  logic [AXI_DATA_WIDTH-1:0] s_rx_axis_tdata;
  logic                      s_rx_axis_tvalid;
  logic                      s_rx_axis_tlast;
  logic                      s_rx_axis_trdy;

  logic                      m_hdr_valid;
  logic                      m_hdr_rdy;
  mac_addr_t                 m_hdr_dest_mac;
  mac_addr_t                 m_hdr_src_mac;
  ethertype_t                m_hdr_ethertype;

  logic [AXI_DATA_WIDTH-1:0] m_pld_axis_tdata;
  logic                      m_pld_axis_tvalid;
  logic                      m_pld_axis_tlast;
  logic                      m_pld_axis_trdy;

  modport master (
    input  s_rx_axis_tdata, s_rx_axis_tvalid, s_rx_axis_tlast,
    output s_rx_axis_trdy,
    output m_hdr_valid, m_hdr_dest_mac, m_hdr_src_mac, m_hdr_ethertype,
    input  m_hdr_rdy,
    output m_pld_axis_tdata, m_pld_axis_tvalid, m_pld_axis_tlast,
    input  m_pld_axis_trdy
  );

  modport slave (
    output s_rx_axis_tdata, s_rx_axis_tvalid, s_rx_axis_tlast,
    input  s_rx_axis_trdy,
    input  m_hdr_valid, m_hdr_dest_mac, m_hdr_src_mac, m_hdr_ethertype,
    output m_hdr_rdy,
    input  m_pld_axis_tdata, m_pld_axis_tvalid, m_pld_axis_tlast,
    output m_pld_axis_trdy
  );

endinterface

// File: rtl/eth_rx_hdr_parser_axis_reg_slice.sv
// Single-entry AXI-stream register slice; accepts a new beat whenever the held one drains
// in the same cycle, so it sustains one beat per clock.
module axis_reg_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  input  logic                  in_tlast,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  input  logic                  out_tready
);

  assign in_tready = out_tready | ~out_tvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (in_tvalid && in_tready) begin
      out_tdata  <= in_tdata;
      out_tvalid <= 1'b1;
      out_tlast  <= in_tlast;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_rx_hdr_parser.sv
// Ethernet II RX header parser: strips the 14-byte header onto a valid/ready channel and
// forwards the payload through a register slice. Optional filter: ETH_RX_MAC_FILTER_EN.
module eth_rx_hdr_parser
  import eth_rx_pkg::*;
#(
  parameter int        AXI_DATA_WIDTH = 8,
  parameter mac_addr_t LOCAL_MAC      = 48'h000A35000102,
  parameter int        CNT_WIDTH      = 16
) (
  input  logic                 clk_100,
  input  logic                 reset_n,
  eth_rx_hdr_parser_if.master  bus,
  output logic                 o_short_err,
  output logic [CNT_WIDTH-1:0] o_frame_cnt,
`ifdef ETH_RX_MAC_FILTER_EN
  output logic [CNT_WIDTH-1:0] o_filt_cnt,
`endif
  output logic [CNT_WIDTH-1:0] o_err_cnt
);

  localparam logic [3:0] LAST_HDR_IDX = 4'(ETH_HDR_BYTES - 1);

  parser_state_t state;
  logic [3:0]    byte_cnt;
  logic [111:0]  hdr_reg;
  logic [111:0]  hdr_next;
  logic          hdr_valid;
  logic          rx_trdy;
  logic          rx_xfer;
  logic          slice_in_ready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hdr_next = {hdr_reg[103:0], bus.s_rx_axis_tdata};

  always_comb begin
    rx_trdy = 1'b0;
    case (state)
      HDR:     rx_trdy = 1'b1;
      HDR_OUT: rx_trdy = 1'b0;
      PLD:     rx_trdy = slice_in_ready;
      DROP:    rx_trdy = 1'b1;
      default: rx_trdy = 1'b0;
    endcase
  end

  assign rx_xfer              = bus.s_rx_axis_tvalid & rx_trdy;
  assign bus.s_rx_axis_trdy   = rx_trdy;
  assign bus.m_hdr_valid      = hdr_valid;
  assign bus.m_hdr_dest_mac   = hdr_reg[111:64];
  assign bus.m_hdr_src_mac    = hdr_reg[63:16];
  assign bus.m_hdr_ethertype  = hdr_reg[15:0];

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HDR;
      byte_cnt    <= '0;
      hdr_reg     <= '0;
      hdr_valid   <= 1'b0;
      o_short_err <= 1'b0;
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
`ifdef ETH_RX_MAC_FILTER_EN
      o_filt_cnt  <= '0;
`endif
    end else begin
      o_short_err <= 1'b0;
      case (state)
        HDR: begin
          if (rx_xfer) begin
            hdr_reg <= hdr_next;
            // tlast anywhere in the first 14 bytes leaves no room for a payload.
            if (bus.s_rx_axis_tlast) begin
              byte_cnt    <= '0;
              o_short_err <= 1'b1;
              o_err_cnt   <= sat_inc(o_err_cnt);
            end else if (byte_cnt == LAST_HDR_IDX) begin
              byte_cnt <= '0;
`ifdef ETH_RX_MAC_FILTER_EN
              if (mac_accepted(hdr_next[111:64], LOCAL_MAC)) begin
                state     <= HDR_OUT;
                hdr_valid <= 1'b1;
              end else begin
                state      <= DROP;
                o_filt_cnt <= sat_inc(o_filt_cnt);
              end
`else
              state     <= HDR_OUT;
              hdr_valid <= 1'b1;
`endif
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        HDR_OUT: begin
          if (bus.m_hdr_rdy) begin
            hdr_valid   <= 1'b0;
            o_frame_cnt <= sat_inc(o_frame_cnt);
            state       <= PLD;
          end
        end
        PLD, DROP: begin
          if (rx_xfer && bus.s_rx_axis_tlast) begin
            state    <= HDR;
            byte_cnt <= '0;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

  axis_reg_slice #(.DATA_WIDTH(AXI_DATA_WIDTH)) u_pld_slice (
    .clk        (clk_100),
    .rst_n      (reset_n),
    .in_tdata   (bus.s_rx_axis_tdata),
    .in_tvalid  (bus.s_rx_axis_tvalid && (state == PLD)),
    .in_tlast   (bus.s_rx_axis_tlast),
    .in_tready  (slice_in_ready),
    .out_tdata  (bus.m_pld_axis_tdata),
    .out_tvalid (bus.m_pld_axis_tvalid),
    .out_tlast  (bus.m_pld_axis_tlast),
    .out_tready (bus.m_pld_axis_trdy)
  );

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// Scoreboard bench for eth_rx_hdr_parser: stimulus queues expected headers/payload,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_eth_rx_hdr_parser;
  import eth_rx_pkg::*;

  localparam int        CNT_WIDTH = 16;
  localparam mac_addr_t LOCAL_MAC = 48'h000A35000102;
  localparam mac_addr_t SRC_MAC   = 48'hDEADBEEF0001;

  typedef struct packed {
    mac_addr_t  dest;
    mac_addr_t  src;
    ethertype_t etype;
  } hdr_t;

  logic clk_100 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_100 = ~clk_100;

  eth_rx_hdr_parser_if bus ();
  logic                 o_short_err;
  logic [CNT_WIDTH-1:0] o_frame_cnt;
  logic [CNT_WIDTH-1:0] o_err_cnt;
`ifdef ETH_RX_MAC_FILTER_EN
  logic [CNT_WIDTH-1:0] o_filt_cnt;
`endif

  eth_rx_hdr_parser #(.LOCAL_MAC(LOCAL_MAC), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_100     (clk_100),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_short_err (o_short_err),
    .o_frame_cnt (o_frame_cnt),
`ifdef ETH_RX_MAC_FILTER_EN
    .o_filt_cnt  (o_filt_cnt),
`endif
    .o_err_cnt   (o_err_cnt)
  );

  hdr_t       hdr_q[$];
  logic [8:0] pld_q[$];
  int         exp_short = 0;
  int         exp_frames = 0, exp_errs = 0, exp_filt = 0;
  int         n_checks = 0, n_fail = 0;
  bit         rand_pld = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [127:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Payload consumer ready: always 1, or a coin flip per cycle when rand_pld is set.
  initial begin
    bus.m_pld_axis_trdy = 1'b1;
    forever begin
      @(posedge clk_100);
      #1;
      bus.m_pld_axis_trdy = rand_pld ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    hdr_t       cur_hdr, held_hdr, exp_h;
    logic [8:0] cur_pld, held_pld, exp_p;
    logic       hdr_held, hdr_acc_prev, pld_held, short_prev;
    hdr_held = 0; hdr_acc_prev = 0; pld_held = 0; short_prev = 0;
    held_hdr = '0; held_pld = '0;
    forever begin
      @(negedge clk_100);
      cur_hdr = {bus.m_hdr_dest_mac, bus.m_hdr_src_mac, bus.m_hdr_ethertype};
      cur_pld = {bus.m_pld_axis_tlast, bus.m_pld_axis_tdata};
      if (!reset_n) begin
        hdr_held = 0; hdr_acc_prev = 0; pld_held = 0; short_prev = 0;
      end else begin
        if (hdr_acc_prev) check("hdr_valid_drop", 128'(bus.m_hdr_valid), 128'(0));
        if (bus.m_hdr_valid) begin
          check("hdr_out_rx_trdy", 128'(bus.s_rx_axis_trdy), 128'(0));
          if (hdr_held) check("hdr_stable", 128'(cur_hdr), 128'(held_hdr));
        end
        hdr_acc_prev = bus.m_hdr_valid & bus.m_hdr_rdy;
        if (bus.m_hdr_valid && bus.m_hdr_rdy) begin
          if (hdr_q.size() == 0) report_fail("hdr_unexpected", 128'(cur_hdr));
          else begin
            exp_h = hdr_q.pop_front();
            check("hdr_fields", 128'(cur_hdr), 128'(exp_h));
          end
        end
        hdr_held = bus.m_hdr_valid & ~bus.m_hdr_rdy;
        held_hdr = cur_hdr;

        if (pld_held) check("pld_stable", 128'({bus.m_pld_axis_tvalid, cur_pld}), 128'({1'b1, held_pld}));
        if (bus.m_pld_axis_tvalid && bus.m_pld_axis_trdy) begin
          if (pld_q.size() == 0) report_fail("pld_unexpected", 128'(cur_pld));
          else begin
            exp_p = pld_q.pop_front();
            check("pld_byte", 128'(cur_pld), 128'(exp_p));
          end
        end
        pld_held = bus.m_pld_axis_tvalid & ~bus.m_pld_axis_trdy;
        held_pld = cur_pld;

        if (o_short_err) begin
          check("short_width", 128'(short_prev), 128'(0));
          check("short_expected", 128'(exp_short > 0), 128'(1));
          if (exp_short > 0) exp_short--;
        end
        short_prev = o_short_err;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic acc;
    int   guard;
    bus.s_rx_axis_tdata  = d;
    bus.s_rx_axis_tvalid = 1'b1;
    bus.s_rx_axis_tlast  = l;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 2000) begin
      @(negedge clk_100);
      acc = bus.s_rx_axis_trdy;
      @(posedge clk_100);
      #1;
      guard++;
    end
    bus.s_rx_axis_tvalid = 1'b0;
    bus.s_rx_axis_tlast  = 1'b0;
    if (!acc) report_fail("send_timeout", 128'(d));
  endtask

  task automatic send_header(input mac_addr_t dest, input mac_addr_t src, input ethertype_t et);
    for (int i = 0; i < 6; i++) send_byte(dest[47-8*i -: 8], 1'b0);
    for (int i = 0; i < 6; i++) send_byte(src[47-8*i -: 8], 1'b0);
    send_byte(et[15:8], 1'b0);
    send_byte(et[7:0], 1'b0);
  endtask

  task automatic send_frame(input mac_addr_t dest, input ethertype_t et, input int npld);
    bit pass;
`ifdef ETH_RX_MAC_FILTER_EN
    pass = (dest == LOCAL_MAC) || (dest == 48'hFFFF_FFFF_FFFF);
`else
    pass = 1'b1;
`endif
    if (pass) begin
      hdr_q.push_back({dest, SRC_MAC, et});
      exp_frames++;
      for (int i = 0; i < npld; i++) pld_q.push_back({i == npld - 1, 8'(i)});
    end else begin
      exp_filt++;
    end
    send_header(dest, SRC_MAC, et);
    for (int i = 0; i < npld; i++) send_byte(8'(i), i == npld - 1);
  endtask

  task automatic send_short(input int n);
    exp_short++;
    exp_errs++;
    for (int i = 0; i < n; i++) send_byte(8'(8'hA0 + i), i == n - 1);
  endtask

  task automatic drain_and_count(input string tag);
    int guard;
    guard = 0;
    while ((hdr_q.size() != 0 || pld_q.size() != 0 || exp_short != 0) && guard < 3000) begin
      @(posedge clk_100);
      guard++;
    end
    if (guard >= 3000) report_fail({tag, "_drain_timeout"}, 128'(pld_q.size()));
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    check({tag, "_frame_cnt"}, 128'(o_frame_cnt), 128'(exp_frames));
    check({tag, "_err_cnt"}, 128'(o_err_cnt), 128'(exp_errs));
`ifdef ETH_RX_MAC_FILTER_EN
    check({tag, "_filt_cnt"}, 128'(o_filt_cnt), 128'(exp_filt));
`endif
    $display("[%0t] %s: frames=%0d errs=%0d filtered=%0d", $time, tag, o_frame_cnt, o_err_cnt, exp_filt);
    @(posedge clk_100);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_trdy"}, 128'(bus.s_rx_axis_trdy), 128'(1));
    check({tag, "_hdr_valid"}, 128'(bus.m_hdr_valid), 128'(0));
    check({tag, "_hdr_fields"}, 128'({bus.m_hdr_dest_mac, bus.m_hdr_src_mac, bus.m_hdr_ethertype}), 128'(0));
    check({tag, "_pld"}, 128'({bus.m_pld_axis_tvalid, bus.m_pld_axis_tlast, bus.m_pld_axis_tdata}), 128'(0));
    check({tag, "_counters"}, 128'({o_short_err, o_frame_cnt, o_err_cnt}), 128'(0));
  endtask

  initial begin
    bus.s_rx_axis_tdata  = '0;
    bus.s_rx_axis_tvalid = 1'b0;
    bus.s_rx_axis_tlast  = 1'b0;
    bus.m_hdr_rdy        = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk_100);
    #1;

    // 1: nominal frame, everything ready
    send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 46);
    drain_and_count("t1_nominal");

    // 2: header stalled 10 cycles, random payload backpressure
    bus.m_hdr_rdy = 1'b0;
    rand_pld = 1'b1;
    fork
      send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 46);
      begin
        int guard;
        guard = 0;
        while (!bus.m_hdr_valid && guard < 500) begin
          @(negedge clk_100);
          guard++;
        end
        if (guard >= 500) report_fail("t2_hdr_valid_timeout", 128'(bus.m_hdr_valid));
        repeat (10) @(posedge clk_100);
        @(negedge clk_100);
        check("t2_hdr_still_valid", 128'(bus.m_hdr_valid), 128'(1));
        @(posedge clk_100);
        #1;
        bus.m_hdr_rdy = 1'b1;
      end
    join
    drain_and_count("t2_stall");
    rand_pld = 1'b0;

    // 3: 10-byte runt followed by a 60-byte frame
    send_short(10);
    send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 46);
    drain_and_count("t3_runt");

    // 4: exactly 14 bytes is still short
    send_short(14);
    drain_and_count("t4_hdr_only");

    // 5: foreign unicast, broadcast, local address
    send_frame(48'h112233445566, ETHERTYPE_IPV4, 46);
    send_frame(48'hFFFFFFFFFFFF, 16'h0806, 46);
    send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 46);
    drain_and_count("t5_filter");

    // 6: reset mid-payload, then a clean frame
    hdr_q.push_back({LOCAL_MAC, SRC_MAC, ETHERTYPE_IPV4});
    for (int i = 0; i < 46; i++) pld_q.push_back({i == 45, 8'(i)});
    send_header(LOCAL_MAC, SRC_MAC, ETHERTYPE_IPV4);
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_async_reset");
    hdr_q.delete();
    pld_q.delete();
    exp_short = 0; exp_frames = 0; exp_errs = 0; exp_filt = 0;
    @(negedge clk_100);
    reset_n = 1'b1;
    @(posedge clk_100);
    #1;
    send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 46);
    drain_and_count("t6_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
